// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch stage: issues word reads to a one-cycle memory, buffers
// {pc, iw} pairs in a prefetch FIFO and hands them to ID over a valid/ready handshake.
module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        memIfReq,
    output logic [29:0] memIfAddr,
    input  logic [31:0] memIfData,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] iw_out,
    output logic [31:0] pc_out
);

    localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CntW:0] DepthC = (CntW + 1)'(FIFO_DEPTH);

    logic [29:0]     fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [31:0]     inflight_pc_q, inflight_pc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0] fifo_pc_q [FIFO_DEPTH];
    logic [31:0] fifo_iw_q [FIFO_DEPTH];

    logic [CntW:0] occupancy;
    logic          credit;
    logic          not_empty;
    logic          push;
    logic          pop;
    logic          unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

    // Credit counts the in-flight response so a full FIFO can never be overrun.
    assign occupancy = {1'b0, count_q} + {{CntW{1'b0}}, inflight_q};
    assign credit    = occupancy < DepthC;
    assign not_empty = count_q != '0;

    assign memIfReq  = reset && !redirect_valid && credit;
    assign memIfAddr = fetch_pc_q;
    assign id_valid  = not_empty && !redirect_valid;
    assign iw_out    = not_empty ? fifo_iw_q[rd_ptr_q] : 32'h0;
    assign pc_out    = not_empty ? fifo_pc_q[rd_ptr_q] : 32'h0;

    assign push = inflight_q && !redirect_valid;
    assign pop  = id_valid && id_ready;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = memIfReq;
        inflight_pc_d = inflight_pc_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;

        if (memIfReq) begin
            fetch_pc_d    = fetch_pc_q + 30'd1;
            inflight_pc_d = {fetch_pc_q, 2'b00};
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc[31:2];
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CntW'(1);
                2'b01:   count_d = count_q - CntW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q    <= RESET_VECTOR[31:2];
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
        end
    end

    // Storage needs no reset: entries are only visible while count is nonzero.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q] <= inflight_pc_q;
            fifo_iw_q[wr_ptr_q] <= memIfData;
        end
    end

endmodule
